// File: rtl/sail_dsp_pkg.sv
// sail_dsp_pkg
//   Shared constants for the sail-core DSP wrappers.
//   DSP_W    : datapath width of the shared DSP subtractor.
//   ID_W     : width of the requester tag carried with each operation.
//   NREQ_MAX : largest number of requesters a sharing arbiter supports.
//   wrap_inc : (v + 1) mod n for small requester indices.
package sail_dsp_pkg;

  localparam int DSP_W    = 32;
  localparam int ID_W     = 2;
  localparam int NREQ_MAX = 4;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
    int t;
    t = int'(v) + 1;
    if (t >= n) t = 0;
    return ID_W'(t);
  endfunction

endpackage

// File: rtl/dsp_subtractor.sv
// dsp_subtractor
//   Combinational 32-bit A - B, standing in for the SB_MAC16 configured
//   as an adder/subtractor with every internal register bypassed.
//   Unsigned wrap-around, no borrow output.
// Ports:
//   i_a    : minuend
//   i_b    : subtrahend
//   o_diff : i_a - i_b mod 2^W
module dsp_subtractor #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff
);

  assign o_diff = i_a - i_b;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin grant. The request with the smallest
//   distance (j - ptr) mod NREQ wins. Grant is suppressed when i_en is low.
// Ports:
//   i_req      : request vector
//   i_ptr      : index with highest priority this cycle
//   i_en       : grant enable (downstream stage can take an entry)
//   o_gnt      : one-hot grant, zero when no request or i_en low
//   o_next_ptr : winner + 1 mod NREQ on a grant, else i_ptr
module rr_arbiter
  import sail_dsp_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_next_ptr
);

  logic w_found;
  int   w_dist;

  always_comb begin
    o_gnt      = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    w_dist     = 0;
    // Outer loop walks priority distance, inner loop finds the requester
    // at that distance; avoids variable-width indexing into i_req.
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        w_dist = j - int'(i_ptr);
        if (w_dist < 0) w_dist = w_dist + NREQ;
        if (!w_found && i_req[j] && (w_dist == k)) begin
          w_found = 1'b1;
          if (i_en) begin
            o_gnt[j]   = 1'b1;
            o_next_ptr = wrap_inc(ID_W'(j), NREQ);
          end
        end
      end
    end
  end

endmodule

// File: rtl/dsp_sub_arbiter.sv
// dsp_sub_arbiter
//   Shares one dsp_subtractor between NREQ (2..4) requesters. Round-robin
//   grant into an operand register (S1), DSP between S1 and a result
//   register (S2), S2 drives a tagged valid/ready response channel.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (at most one ready high)
//   req_a/req_b         : packed operands, requester i at [32*i +: 32]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : requester index of the response
//   rsp_data, rsp_zero  : a - b mod 2^32 and (difference == 0)
//   busy                : either pipeline stage holds a valid entry
module dsp_sub_arbiter
  import sail_dsp_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [DSP_W*NREQ-1:0]   req_a,
  input  logic [DSP_W*NREQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DSP_W-1:0]        rsp_data,
  output logic                    rsp_zero,
  output logic                    busy
);

  // S1: operand register
  logic              r_s1_v;
  logic [DSP_W-1:0]  r_s1_a;
  logic [DSP_W-1:0]  r_s1_b;
  logic [ID_W-1:0]   r_s1_id;
  // S2: result register
  logic              r_s2_v;
  logic [DSP_W-1:0]  r_s2_data;
  logic              r_s2_zero;
  logic [ID_W-1:0]   r_s2_id;

  logic [ID_W-1:0]   r_rr_ptr;

  logic              w_s2_free;
  logic              w_s1_adv;
  logic              w_s1_free;
  logic [NREQ-1:0]   w_gnt;
  logic [ID_W-1:0]   w_next_ptr;
  logic              w_accept;
  logic [ID_W-1:0]   w_gnt_id;
  logic [DSP_W-1:0]  w_sel_a;
  logic [DSP_W-1:0]  w_sel_b;
  logic [DSP_W-1:0]  w_diff;
  logic              w_s1_eq;

  assign w_s2_free = !r_s2_v || rsp_ready;
  assign w_s1_adv  = r_s1_v && w_s2_free;
  assign w_s1_free = !r_s1_v || w_s1_adv;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req      (req_valid),
    .i_ptr      (r_rr_ptr),
    .i_en       (w_s1_free),
    .o_gnt      (w_gnt),
    .o_next_ptr (w_next_ptr)
  );

  // Grant is only non-zero for a valid request with S1 free, so any grant
  // bit is an accept.
  assign req_ready = w_gnt;
  assign w_accept  = |w_gnt;

  always_comb begin
    w_gnt_id = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt[j]) begin
        w_gnt_id = ID_W'(j);
        w_sel_a  = req_a[DSP_W*j +: DSP_W];
        w_sel_b  = req_b[DSP_W*j +: DSP_W];
      end
    end
  end

  dsp_subtractor #(.W(DSP_W)) u_dsp (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_diff (w_diff)
  );

  // a - b == 0 exactly when a == b; comparing the operands directly keeps
  // the zero detect off the DSP carry chain.
  assign w_s1_eq = (r_s1_a == r_s1_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v  <= 1'b0;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
      r_s1_id <= '0;
    end else begin
      if (w_accept) begin
        r_s1_v  <= 1'b1;
        r_s1_a  <= w_sel_a;
        r_s1_b  <= w_sel_b;
        r_s1_id <= w_gnt_id;
      end else if (w_s1_adv) begin
        r_s1_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_zero <= 1'b0;
      r_s2_id   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s2_v    <= 1'b1;
        r_s2_data <= w_diff;
        r_s2_zero <= w_s1_eq;
        r_s2_id   <= r_s1_id;
      end else if (rsp_ready) begin
        r_s2_v <= 1'b0;
      end
    end
  end

  // Arbiter returns the current pointer when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  assign rsp_valid = r_s2_v;
  assign rsp_data  = r_s2_data;
  assign rsp_zero  = r_s2_zero;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1_v || r_s2_v;

endmodule

// File: tb/tb_dsp_sub_arbiter.sv
module tb_dsp_sub_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NREQ = 2 instance
  logic [1:0]  req_valid2 = '0;
  logic [1:0]  req_ready2;
  logic [63:0] req_a2 = '0;
  logic [63:0] req_b2 = '0;
  logic        rsp_valid2;
  logic        rsp_ready2 = 1'b0;
  logic [1:0]  rsp_id2;
  logic [31:0] rsp_data2;
  logic        rsp_zero2;
  logic        busy2;

  // NREQ = 4 instance
  logic [3:0]   req_valid4 = '0;
  logic [3:0]   req_ready4;
  logic [127:0] req_a4 = '0;
  logic [127:0] req_b4 = '0;
  logic         rsp_valid4;
  logic         rsp_ready4 = 1'b0;
  logic [1:0]   rsp_id4;
  logic [31:0]  rsp_data4;
  logic         rsp_zero4;
  logic         busy4;

  dsp_sub_arbiter #(.NREQ(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_id(rsp_id2), .rsp_data(rsp_data2), .rsp_zero(rsp_zero2),
    .busy(busy2)
  );

  dsp_sub_arbiter #(.NREQ(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_id(rsp_id4), .rsp_data(rsp_data4), .rsp_zero(rsp_zero4),
    .busy(busy4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ptr = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int i);
    logic [31:0] one;
    one = 32'd1;
    return one << i;
  endfunction

  // One isolated operation on dut2 with rsp_ready held high.
  task automatic single_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_z);
    @(posedge clk); #1;
    rsp_ready2 = 1'b1;
    req_valid2 = 2'(oh(idx));
    req_a2[32*idx +: 32] = a;
    req_b2[32*idx +: 32] = b;
    @(negedge clk);
    check_eq("single_rdy", 32'(req_ready2), oh(idx));
    @(posedge clk); #1;
    req_valid2 = '0;
    exp_ptr = (idx + 1) % 2;
    @(negedge clk);
    check_eq("single_lat", 32'(rsp_valid2), 32'd0);
    @(negedge clk);
    check_eq("single_v", 32'(rsp_valid2), 32'd1);
    check_eq("single_data", rsp_data2, exp_d);
    check_eq("single_zero", 32'(rsp_zero2), 32'(exp_z));
    check_eq("single_id", 32'(rsp_id2), 32'(idx));
    $display("[TB] op req%0d a=0x%08h b=0x%08h -> data=0x%08h zero=%0d id=%0d",
             idx, a, b, rsp_data2, rsp_zero2, rsp_id2);
    @(negedge clk);
    check_eq("single_idle", 32'(busy2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int g_hist[$];
    int cnt[4];

    // ---- reset state ----
    req_valid2 = 2'b01;
    #3;
    check_eq("rst_valid", 32'(rsp_valid2), 32'd0);
    check_eq("rst_busy", 32'(busy2), 32'd0);
    check_eq("rst_data", rsp_data2, 32'd0);
    check_eq("rst_id", 32'(rsp_id2), 32'd0);
    check_eq("rst_zero", 32'(rsp_zero2), 32'd0);
    check_eq("rst_ready", 32'(req_ready2), 32'd1);
    req_valid2 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- single ops, wrap and zero ----
    single_op(0, 32'd5, 32'd3, 32'd2, 1'b0);
    single_op(0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    single_op(1, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1);
    single_op(0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);

    // ---- contention, NREQ=2: req0 10-1=9, req1 20-5=15 ----
    @(posedge clk); #1;
    rsp_ready2 = 1'b1;
    req_a2 = {32'd20, 32'd10};
    req_b2 = {32'd5, 32'd1};
    req_valid2 = 2'b11;
    g = exp_ptr;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("cont_rdy", 32'(req_ready2), oh(g));
      if (k >= 2) begin
        check_eq("cont_v", 32'(rsp_valid2), 32'd1);
        check_eq("cont_id", 32'(rsp_id2), 32'(g_hist[k-2]));
        check_eq("cont_data", rsp_data2, (g_hist[k-2] == 1) ? 32'd15 : 32'd9);
        $display("[TB] contention rsp id=%0d data=%0d", rsp_id2, rsp_data2);
      end
      g_hist.push_back(g);
      @(posedge clk); #1;
      g = 1 - g;
    end
    req_valid2 = '0;
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      check_eq("cont_drain_id", 32'(rsp_id2), 32'(g_hist[k-2]));
      check_eq("cont_drain_data", rsp_data2, (g_hist[k-2] == 1) ? 32'd15 : 32'd9);
    end
    @(negedge clk);
    check_eq("cont_idle", 32'(rsp_valid2), 32'd0);

    // ---- back-pressure: A=100-1 (req0), B=200-2 (req1), C=300-3 (req0) ----
    @(posedge clk); #1;
    rsp_ready2 = 1'b0;
    req_a2[31:0] = 32'd100; req_b2[31:0] = 32'd1;
    req_valid2 = 2'b01;
    @(negedge clk);
    check_eq("bp_rdyA", 32'(req_ready2), 32'd1);
    @(posedge clk); #1;
    req_a2[63:32] = 32'd200; req_b2[63:32] = 32'd2;
    req_valid2 = 2'b10;
    @(negedge clk);
    check_eq("bp_rdyB", 32'(req_ready2), 32'd2);
    @(posedge clk); #1;
    req_a2[31:0] = 32'd300; req_b2[31:0] = 32'd3;
    req_valid2 = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_rdyC_blocked", 32'(req_ready2), 32'd0);
      check_eq("bp_hold_v", 32'(rsp_valid2), 32'd1);
      check_eq("bp_hold_data", rsp_data2, 32'd99);
      check_eq("bp_hold_id", 32'(rsp_id2), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready2 = 1'b1;
    @(negedge clk);
    check_eq("bp_rdyC_free", 32'(req_ready2), 32'd1);
    check_eq("bp_rsp1_data", rsp_data2, 32'd99);
    $display("[TB] bp rsp id=%0d data=%0d", rsp_id2, rsp_data2);
    @(posedge clk); #1;
    req_valid2 = '0;
    @(negedge clk);
    check_eq("bp_rsp2_data", rsp_data2, 32'd198);
    check_eq("bp_rsp2_id", 32'(rsp_id2), 32'd1);
    $display("[TB] bp rsp id=%0d data=%0d", rsp_id2, rsp_data2);
    @(negedge clk);
    check_eq("bp_rsp3_data", rsp_data2, 32'd297);
    check_eq("bp_rsp3_id", 32'(rsp_id2), 32'd0);
    $display("[TB] bp rsp id=%0d data=%0d", rsp_id2, rsp_data2);
    @(negedge clk);
    check_eq("bp_no_dup", 32'(rsp_valid2), 32'd0);

    // ---- reset mid-op: req1 50-8 sits in S2, req0 7-2 sits in S1 ----
    @(posedge clk); #1;
    rsp_ready2 = 1'b0;
    req_a2[63:32] = 32'd50; req_b2[63:32] = 32'd8;
    req_valid2 = 2'b10;
    @(negedge clk);
    check_eq("rm_rdy1", 32'(req_ready2), 32'd2);
    @(posedge clk); #1;
    req_a2[31:0] = 32'd7; req_b2[31:0] = 32'd2;
    req_valid2 = 2'b01;
    @(negedge clk);
    check_eq("rm_rdy0", 32'(req_ready2), 32'd1);
    @(posedge clk); #1;
    req_valid2 = '0;
    check_eq("rm_pre_v", 32'(rsp_valid2), 32'd1);
    check_eq("rm_pre_data", rsp_data2, 32'd42);
    check_eq("rm_pre_busy", 32'(busy2), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rm_v", 32'(rsp_valid2), 32'd0);
    check_eq("rm_busy", 32'(busy2), 32'd0);
    check_eq("rm_data", rsp_data2, 32'd0);
    check_eq("rm_id", 32'(rsp_id2), 32'd0);
    $display("[TB] reset asserted mid-op");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready2 = 1'b1;
    @(negedge clk);
    check_eq("rm_nostale0", 32'(rsp_valid2), 32'd0);
    @(negedge clk);
    check_eq("rm_nostale1", 32'(rsp_valid2), 32'd0);
    check_eq("rm_idle_busy", 32'(busy2), 32'd0);
    @(posedge clk); #1;
    req_a2 = {32'd1, 32'd9};
    req_b2 = {32'd1, 32'd4};
    req_valid2 = 2'b11;
    @(negedge clk);
    check_eq("rm_ptr0_rdy", 32'(req_ready2), 32'd1);
    @(posedge clk); #1;
    req_valid2 = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rm_post_id", 32'(rsp_id2), 32'd0);
    check_eq("rm_post_data", rsp_data2, 32'd5);
    $display("[TB] post-reset rsp id=%0d data=%0d", rsp_id2, rsp_data2);

    // ---- fairness, NREQ=4: req i computes 1000*(i+1) - i ----
    @(posedge clk); #1;
    rsp_ready4 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      req_a4[32*j +: 32] = 32'(1000 * (j + 1));
      req_b4[32*j +: 32] = 32'(j);
      cnt[j] = 0;
    end
    req_valid4 = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_eq("fair_rdy", 32'(req_ready4), oh(k % 4));
      for (int j = 0; j < 4; j++) if (req_ready4[j]) cnt[j]++;
      if (k >= 2) begin
        check_eq("fair_id", 32'(rsp_id4), 32'((k - 2) % 4));
        check_eq("fair_data", rsp_data4, 32'(1000 * (((k - 2) % 4) + 1) - ((k - 2) % 4)));
        $display("[TB] fair rsp id=%0d data=%0d", rsp_id4, rsp_data4);
      end
      @(posedge clk); #1;
    end
    req_valid4 = '0;
    for (int k = 12; k < 14; k++) begin
      @(negedge clk);
      check_eq("fair_drain_id", 32'(rsp_id4), 32'((k - 2) % 4));
    end
    @(negedge clk);
    check_eq("fair_idle", 32'(busy4), 32'd0);
    for (int j = 0; j < 4; j++) check_eq("fair_count", 32'(cnt[j]), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
